// File: rtl/pc_predict_unit_pkg.sv
// Shared definitions for the fetch-stage next-PC predictor: Y86-64 icodes,
// jXX prediction policy encodings and the fetch FSM state type.
package pc_predict_unit_pkg;

    localparam logic [3:0] IHALT = 4'd0;
    localparam logic [3:0] IJXX  = 4'd7;
    localparam logic [3:0] ICALL = 4'd8;
    localparam logic [3:0] IRET  = 4'd9;

    localparam int PRED_TAKEN    = 0;
    localparam int PRED_NOTTAKEN = 1;
    localparam int PRED_BTFN     = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_RET = 2'd1,
        HALTED   = 2'd2
    } state_t;

endpackage

// File: rtl/pc_predict_unit_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and the occupancy count saturates at DEPTH.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_dec;

    // ptr addresses the next free slot; the top of stack sits just below it
    assign ptr_dec = ptr - PTR_W'(1);
    assign top     = mem[ptr_dec];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr + PTR_W'(1);
            count <= full ? count : count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - CNT_W'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; count gates every read,
    // so stale contents are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage next-PC generator: static jXX prediction, RAS for call/ret,
// late redirects from memory/write-back, stall, halt and empty-RAS ret waiting.
module pc_predict_unit
    import pc_predict_unit_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 8,
    parameter int                PRED_MODE = 0,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_valid,
    input  logic [3:0]                 f_icode,
    input  logic [3:0]                 f_ifun,
    input  logic [ADDR_W-1:0]          f_valC,
    input  logic [ADDR_W-1:0]          f_valP,
    input  logic                       stall,
    input  logic                       m_redirect,
    input  logic [ADDR_W-1:0]          m_target,
    input  logic                       w_redirect,
    input  logic [ADDR_W-1:0]          w_target,
    output logic [ADDR_W-1:0]          pc,
    output logic                       f_pred_taken,
    output logic                       f_ret_pred,
    output logic                       f_bubble,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              jxx_taken;
    logic              fetch_live;
    logic              advance;
    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (f_valP),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        jxx_taken = (f_ifun == 4'd0)
                 || (PRED_MODE == PRED_TAKEN)
                 || ((PRED_MODE == PRED_BTFN) && (f_valC < f_valP));

        fetch_live   = (state == RUN) && f_valid;
        f_pred_taken = fetch_live && (f_icode == IJXX) && jxx_taken;
        f_ret_pred   = fetch_live && (f_icode == IRET) && !ras_empty;
        f_bubble     = (state != RUN);

        // Predictions only commit when nothing older overrides this cycle
        advance  = fetch_live && !stall && !m_redirect && !w_redirect;
        ras_push = advance && (f_icode == ICALL);
        ras_pop  = advance && (f_icode == IRET) && !ras_empty;

        pc_nxt    = pc;
        state_nxt = state;

        if (m_redirect) begin
            pc_nxt    = m_target;
            state_nxt = RUN;
        end else if (w_redirect) begin
            pc_nxt    = w_target;
            state_nxt = RUN;
        end else if (advance) begin
            case (f_icode)
                IJXX:    pc_nxt = jxx_taken ? f_valC : f_valP;
                ICALL:   pc_nxt = f_valC;
                IRET: begin
                    if (ras_empty)
                        state_nxt = WAIT_RET;
                    else
                        pc_nxt = ras_top;
                end
                IHALT: begin
                    pc_nxt    = f_valP;
                    state_nxt = HALTED;
                end
                default: pc_nxt = f_valP;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= RUN;
        end else begin
            pc    <= pc_nxt;
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench: stimulus queues hand-computed expectations per cycle, a
// negedge monitor pops and compares against a BTFN DUT and a never-taken DUT.
module tb_pc_predict_unit;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_valid;
    logic [3:0]        f_icode, f_ifun;
    logic [ADDR_W-1:0] f_valC, f_valP;
    logic              stall, m_redirect, w_redirect;
    logic [ADDR_W-1:0] m_target, w_target;

    logic [ADDR_W-1:0] pc, pc_nt;
    logic              f_pred_taken, f_ret_pred, f_bubble;
    logic              nt_taken, nt_ret_pred, nt_bubble;
    logic [2:0]        ras_count, nt_count;

    pc_predict_unit #(
        .ADDR_W(ADDR_W), .RAS_DEPTH(4), .PRED_MODE(2), .RESET_PC(64'h100)
    ) dut (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_icode(f_icode),
        .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP), .stall(stall),
        .m_redirect(m_redirect), .m_target(m_target),
        .w_redirect(w_redirect), .w_target(w_target),
        .pc(pc), .f_pred_taken(f_pred_taken), .f_ret_pred(f_ret_pred),
        .f_bubble(f_bubble), .ras_count(ras_count)
    );

    pc_predict_unit #(
        .ADDR_W(ADDR_W), .RAS_DEPTH(4), .PRED_MODE(1), .RESET_PC(64'h100)
    ) dut_nt (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_icode(f_icode),
        .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP), .stall(stall),
        .m_redirect(m_redirect), .m_target(m_target),
        .w_redirect(w_redirect), .w_target(w_target),
        .pc(pc_nt), .f_pred_taken(nt_taken), .f_ret_pred(nt_ret_pred),
        .f_bubble(nt_bubble), .ras_count(nt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        string             name;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_nt;
        logic              taken;
        logic              ret_pred;
        logic              bubble;
        logic [2:0]        cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [ADDR_W-1:0] act,
                         input logic [ADDR_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: compares the queued expectation that belongs to this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d not observed (now %0d)",
                     q[0].name, q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            check({e.name, ".pc"},       pc,                     e.pc);
            check({e.name, ".pc_nt"},    pc_nt,                  e.pc_nt);
            check({e.name, ".taken"},    ADDR_W'(f_pred_taken),  ADDR_W'(e.taken));
            check({e.name, ".ret_pred"}, ADDR_W'(f_ret_pred),    ADDR_W'(e.ret_pred));
            check({e.name, ".bubble"},   ADDR_W'(f_bubble),      ADDR_W'(e.bubble));
            check({e.name, ".count"},    ADDR_W'(ras_count),     ADDR_W'(e.cnt));
        end
    end

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [ADDR_W-1:0] vc, input logic [ADDR_W-1:0] vp,
                         input logic st, input logic mr, input logic [ADDR_W-1:0] mt,
                         input logic wr, input logic [ADDR_W-1:0] wt);
        f_valid    = v;
        f_icode    = ic;
        f_ifun     = fn;
        f_valC     = vc;
        f_valP     = vp;
        stall      = st;
        m_redirect = mr;
        m_target   = mt;
        w_redirect = wr;
        w_target   = wt;
    endtask

    task automatic idle();
        drive(1'b0, 4'd1, 4'd0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic exp_out(input string nm, input logic [ADDR_W-1:0] p,
                           input logic [ADDR_W-1:0] pn, input logic tk,
                           input logic rp, input logic bb, input logic [2:0] c);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.pc = p; e.pc_nt = pn;
        e.taken = tk; e.ret_pred = rp; e.bubble = bb; e.cnt = c;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        exp_out("rst", 64'h100, 64'h100, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // Sequential instruction advances to valP
        drive(1, 4'd1, 4'd0, 64'h0, 64'h102, 0, 0, '0, 0, '0);
        exp_out("seq", 64'h100, 64'h100, 0, 0, 0, 0);
        tick();
        // Backward conditional jump: BTFN takes, never-taken falls through
        drive(1, 4'd7, 4'd1, 64'h040, 64'h10A, 0, 0, '0, 0, '0);
        exp_out("jxx_back", 64'h102, 64'h102, 1, 0, 0, 0);
        tick();
        drive(0, 4'd1, 4'd0, '0, '0, 0, 1, 64'h10A, 0, '0);
        exp_out("jxx_pred", 64'h040, 64'h10A, 0, 0, 0, 0);
        tick();
        // Unconditional jmp taken in every mode
        drive(1, 4'd7, 4'd0, 64'h020, 64'h10F, 0, 0, '0, 0, '0);
        exp_out("m_redir", 64'h10A, 64'h10A, 1, 0, 0, 0);
        tick();
        // Forward conditional jump: BTFN does not take
        drive(1, 4'd7, 4'd2, 64'h200, 64'h025, 0, 0, '0, 0, '0);
        exp_out("jmp", 64'h020, 64'h020, 0, 0, 0, 0);
        tick();

        // call then ret through the RAS
        drive(1, 4'd8, 4'd0, 64'h300, 64'h209, 0, 0, '0, 0, '0);
        exp_out("jxx_fwd", 64'h025, 64'h025, 0, 0, 0, 0);
        tick();
        drive(1, 4'd9, 4'd0, '0, 64'h301, 0, 0, '0, 0, '0);
        exp_out("call", 64'h300, 64'h300, 0, 1, 0, 1);
        tick();

        // ret on empty RAS waits for write-back
        drive(1, 4'd9, 4'd0, '0, 64'h20A, 0, 0, '0, 0, '0);
        exp_out("ret_pop", 64'h209, 64'h209, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            exp_out("wait_ret", 64'h209, 64'h209, 0, 0, 1, 0);
            tick();
        end
        drive(0, 4'd1, 4'd0, '0, '0, 0, 0, '0, 1, 64'h555);
        exp_out("wait_w_redir", 64'h209, 64'h209, 0, 0, 1, 0);
        tick();
        drive(1, 4'd2, 4'd0, '0, 64'h557, 0, 0, '0, 0, '0);
        exp_out("w_resume", 64'h555, 64'h555, 0, 0, 0, 0);
        tick();

        // Five calls overflow the 4-deep RAS; pops see the newest four
        for (int i = 0; i < 5; i++) begin
            logic [ADDR_W-1:0] p;
            p = (i == 0) ? 64'h557 : 64'h600 + ADDR_W'(16 * (i - 1));
            drive(1, 4'd8, 4'd0, 64'h600 + ADDR_W'(16 * i), ADDR_W'(16 * (i + 1)),
                  0, 0, '0, 0, '0);
            exp_out("ovf_call", p, p, 0, 0, 0, 3'(i));
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            logic [ADDR_W-1:0] p;
            p = (j == 0) ? 64'h640 : ADDR_W'(16 * (6 - j));
            drive(1, 4'd9, 4'd0, '0, 64'h7, 0, 0, '0, 0, '0);
            exp_out("ovf_ret", p, p, 0, (j < 4), 0, 3'(4 - j));
            tick();
        end
        idle();
        exp_out("ovf_wait", 64'h20, 64'h20, 0, 0, 1, 0);
        tick();

        // Asynchronous reset in the middle of WAIT_RET
        reset = 1'b1;
        #1;
        exp_out("rst_async", 64'h100, 64'h100, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // Halt, then both redirects under stall: memory stage wins
        drive(1, 4'd0, 4'd0, '0, 64'h104, 0, 0, '0, 0, '0);
        exp_out("halt", 64'h100, 64'h100, 0, 0, 0, 0);
        tick();
        idle();
        exp_out("halted", 64'h104, 64'h104, 0, 0, 1, 0);
        tick();
        drive(1, 4'd1, 4'd0, '0, 64'h999, 1, 1, 64'h700, 1, 64'h800);
        exp_out("halted_redir", 64'h104, 64'h104, 0, 0, 1, 0);
        tick();
        drive(1, 4'd1, 4'd0, '0, 64'h702, 0, 0, '0, 0, '0);
        exp_out("m_wins", 64'h700, 64'h700, 0, 0, 0, 0);
        tick();

        // Stalled call must not move pc nor push
        drive(1, 4'd8, 4'd0, 64'h900, 64'h902, 1, 0, '0, 0, '0);
        exp_out("run_after", 64'h702, 64'h702, 0, 0, 0, 0);
        tick();
        idle();
        exp_out("stall_hold", 64'h702, 64'h702, 0, 0, 0, 0);
        tick();

        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Parametrised fetch-stage next-PC generator for the pipelined Y86-64 core. It replaces the single-cycle PC update with an owned fetch-PC register.
- Predicts the next PC from the fetched instruction: jXX uses a selectable static policy; call/ret use a return-address stack (RAS).
- Accepts late corrections from the memory stage (mispredicted jXX) and the write-back stage (resolved ret).
- Handles stall, halt and empty-RAS ret waiting.

Parameters:
- ADDR_W, 64, width of every address/PC bus.
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.
- PRED_MODE, 0, jXX policy: 0 = always taken, 1 = never taken, 2 = backward-taken/forward-not-taken (BTFN).
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch stage holds a decoded instruction this cycle.
- f_icode  in  4  fetched icode (0 halt, 7 jXX, 8 call, 9 ret, others sequential).
- f_ifun  in  4  fetched ifun; jXX with ifun 0 is jmp, always taken.
- f_valC  in  ADDR_W  fetched constant (jump/call target).
- f_valP  in  ADDR_W  fetched sequential next PC.
- stall  in  1  hazard unit holds fetch.
- m_redirect  in  1  memory stage found a mispredicted jXX.
- m_target  in  ADDR_W  correct PC for m_redirect.
- w_redirect  in  1  write-back stage resolved a ret whose predicted target was wrong or absent.
- w_target  in  ADDR_W  correct PC for w_redirect (ret valM).
- pc  out  ADDR_W  current fetch PC.
- f_pred_taken  out  1  the jXX currently in fetch was predicted taken; travels down the pipe.
- f_ret_pred  out  1  the ret currently in fetch got a RAS target.
- f_bubble  out  1  fetch must inject a bubble this cycle (WAIT_RET or HALTED).
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries, for debug and coverage.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=RUN, RAS pointer=0, ras_count=0. All other outputs are 0.
- States: RUN, WAIT_RET, HALTED.
- Per-cycle priority, highest first:
  1. m_redirect: pc<=m_target.
  2. w_redirect: pc<=w_target.
  3. stall: pc, RAS and state hold.
  4. Prediction.
- Either redirect forces state<=RUN. If both redirects are asserted together, m_redirect wins because it is the older instruction.
- RAS is not repaired on redirect. Wrong-path pushes/pops stay; w_redirect guarantees ret correctness.
- Prediction, RUN with f_valid=1 and no stall:
  - icode 7: the taken decision is made as follows.
    - ifun 0 is always taken.
    - Otherwise apply PRED_MODE. BTFN predicts taken when f_valC < f_valP, unsigned compare.
    - pc<=taken ? f_valC : f_valP.
    - f_pred_taken reflects the decision combinationally in the same cycle.
  - icode 8: push f_valP; pc<=f_valC.
  - icode 9:
    - RAS non-empty: pop; pc<=popped value; f_ret_pred=1.
    - RAS empty: f_ret_pred=0; pc holds; state<=WAIT_RET.
  - icode 0: pc<=f_valP; state<=HALTED.
  - Any other icode: pc<=f_valP.
- f_valid=0 in RUN: pc holds.
- WAIT_RET: f_bubble=1; pc holds; leaves only on w_redirect or m_redirect.
- HALTED: f_bubble=1; pc holds; leaves only on a redirect or reset. The halt may be on a speculative path.
- RAS storage is circular.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - Pop decrements the pointer modulo RAS_DEPTH and decrements ras_count.
  - Pointer wrap-around is exercised when pushes exceed RAS_DEPTH.
- Outputs f_pred_taken and f_ret_pred are combinational from the current f_* inputs and RAS state. pc is registered, so next-PC latency is 1 cycle.
- Address arithmetic is not performed; all targets are passed through at ADDR_W.
- Reset asserted mid-operation (stall, WAIT_RET, or a redirect in the same cycle): reset dominates asynchronously.

Decomposition:
- Shared package holds:
  - the icode constants (IHALT=0, IJXX=7, ICALL=8, IRET=9),
  - PRED_MODE encodings (PRED_TAKEN, PRED_NOTTAKEN, PRED_BTFN),
  - the state enum (RUN, WAIT_RET, HALTED).
- One sub-module, ras_stack: params DEPTH and W; ports push, pop, push_data, top, count, empty, full. It holds the circular storage and saturating count.

Test Plan:
- Reset to RESET_PC=0x100. At f_icode 1 with f_valP 0x102 and no stall: pc=0x100 after reset, then 0x102 after one clock.
- jXX ifun 1 with f_valC 0x040 and f_valP 0x10A:
  - PRED_MODE 2 gives pc=0x040, f_pred_taken=1.
  - PRED_MODE 1 gives pc=0x10A.
  - m_redirect with m_target 0x10A in the following cycle gives pc=0x10A.
- call (f_valC 0x300, f_valP 0x209) then ret: pc 0x300, then 0x209 with f_ret_pred=1 and ras_count back to 0.
- ret with empty RAS: f_bubble=1 and pc held for 3 cycles; w_redirect with w_target 0x555 gives pc=0x555, state RUN.
- RAS_DEPTH=4, 5 calls with valP 0x10..0x50, then 5 rets:
  - ras_count saturates at 4;
  - pops return 0x50, 0x40, 0x30, 0x20;
  - the fifth ret enters WAIT_RET.
- Assert m_redirect and w_redirect together while stall=1 and state HALTED: pc=m_target and state=RUN. Reset pulse mid-WAIT_RET gives pc=RESET_PC.
